// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_mdu_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module hilo_mdu_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nx,
  output logic [W-1:0] quo_nx
);

  logic [W:0] sh;
  logic       ge;

  // Shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    sh     = {rem, quo[W-1]};
    ge     = (sh >= {1'b0, dvs});
    rem_nx = ge ? W'(sh - {1'b0, dvs}) : sh[W-1:0];
    quo_nx = {quo[W-2:0], ge};
  end

endmodule

// File: rtl/hilo_mdu.sv
// Multiply/divide unit producing HI/LO write strobes for the pipeline.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DIV_ITERS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              to_hi,
  output logic              to_lo,
  output logic [DATA_W-1:0] to_hi_data,
  output logic [DATA_W-1:0] to_lo_data
);

  localparam int unsigned      CNT_W    = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem_q, quo_q, dvs_q, rem_nx, quo_nx;
  logic [DATA_W-1:0]   hi_q, lo_q, mag_a, mag_b;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic                neg_quo, neg_rem, wr_hi, wr_lo;
  logic                accept, is_mul, is_div, is_mt, is_signed, div_zero, last_step;

  hilo_mdu_div_step #(.W(DATA_W)) u_div_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  // Operation decode, operand magnitudes and the inline product.
  always_comb begin
    accept    = (state == S_IDLE) && start && !flush;
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    is_mt     = (op == OP_MTHI) || (op == OP_MTLO);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    div_zero  = (rt_data == '0);
    last_step = (state == S_DIV) && (cnt == CNT_LAST);
    mag_a     = (is_signed && rs_data[DATA_W-1]) ? -rs_data : rs_data;
    mag_b     = (is_signed && rt_data[DATA_W-1]) ? -rt_data : rt_data;
    // Low 2W bits of the product of extended operands equal the signed or
    // unsigned product depending only on how the operands were extended.
    ext_a     = {{DATA_W{is_signed & rs_data[DATA_W-1]}}, rs_data};
    ext_b     = {{DATA_W{is_signed & rt_data[DATA_W-1]}}, rt_data};
    prod      = ext_a * ext_b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; flush cancels any in-flight operation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_mt)          state_nxt = S_DONE;
          else if (is_div && div_zero)  state_nxt = S_DONE;
          else if (is_div)              state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (flush)          state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, division iteration, result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      wr_hi   <= 1'b0;
      wr_lo   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        hi_q  <= prod[2*DATA_W-1:DATA_W];
        lo_q  <= prod[DATA_W-1:0];
        wr_hi <= 1'b1;
        wr_lo <= 1'b1;
      end else if (is_div && div_zero) begin
        hi_q  <= rs_data;
        lo_q  <= '1;
        wr_hi <= 1'b1;
        wr_lo <= 1'b1;
      end else if (is_div) begin
        rem_q   <= '0;
        quo_q   <= mag_a;
        dvs_q   <= mag_b;
        neg_quo <= is_signed && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
        neg_rem <= is_signed && rs_data[DATA_W-1];
        cnt     <= '0;
        wr_hi   <= 1'b1;
        wr_lo   <= 1'b1;
      end else if (op == OP_MTHI) begin
        hi_q  <= rs_data;
        wr_hi <= 1'b1;
        wr_lo <= 1'b0;
      end else if (op == OP_MTLO) begin
        lo_q  <= rs_data;
        wr_hi <= 1'b0;
        wr_lo <= 1'b1;
      end
    end else if ((state == S_DIV) && !flush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt   <= cnt + 1'b1;
      if (last_step) begin
        lo_q <= neg_quo ? -quo_nx : quo_nx;
        hi_q <= neg_rem ? -rem_nx : rem_nx;
      end
    end
  end

  // Strobes are gated by flush directly so a squash in DONE kills them at once.
  assign busy       = (state != S_IDLE);
  assign to_hi      = (state == S_DONE) && wr_hi && !flush;
  assign to_lo      = (state == S_DONE) && wr_lo && !flush;
  assign to_hi_data = hi_q;
  assign to_lo_data = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed vectors plus a per-cycle model.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy, to_hi, to_lo;
  logic [31:0] to_hi_data, to_lo_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.DATA_W(32), .DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .flush      (flush),
    .busy       (busy),
    .to_hi      (to_hi),
    .to_lo      (to_lo),
    .to_hi_data (to_hi_data),
    .to_lo_data (to_lo_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Behavioural model: arithmetic result and latency from plain integer maths.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l,
                          output logic wh, output logic wl, output int lat);
    logic [63:0] p;
    longint      sa, sb, q, r;
    h = '0; l = '0; wh = 1'b1; wl = 1'b1; lat = 1;
    case (o)
      3'd0: begin sa = $signed(a); sb = $signed(b); p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          lat = 33;
          if (o == 3'd2) begin sa = $signed(a); sb = $signed(b); end
          else begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
          q = sa / sb; r = sa % sb;
          p = q; l = p[31:0];
          p = r; h = p[31:0];
        end
      end
      3'd4: begin h = a; wl = 1'b0; end
      3'd5: begin l = a; wh = 1'b0; end
      default: lat = 0;
    endcase
  endtask

  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_wh = 1'b0, p_wl = 1'b0;
  bit          cmp_en = 1'b0;

  // Model state advance: cycles remaining until idle, result published on strobe cycle.
  always @(posedge clk) begin
    int lat;
    if (!rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0;
    end else if (m_rem > 0) begin
      if (flush) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 1) begin
          if (p_wh) m_hi = p_hi;
          if (p_wl) m_lo = p_lo;
        end
      end
    end else if (start && !flush) begin
      model_op(op, rs_data, rt_data, p_hi, p_lo, p_wh, p_wl, lat);
      m_rem = lat;
      if (m_rem == 1) begin
        if (p_wh) m_hi = p_hi;
        if (p_wl) m_lo = p_lo;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",    32'(busy),  32'(m_rem > 0));
      check("to_hi",   32'(to_hi), 32'((m_rem == 1) && p_wh && !flush));
      check("to_lo",   32'(to_lo), 32'((m_rem == 1) && p_wl && !flush));
      check("hi_data", to_hi_data, m_hi);
      check("lo_data", to_lo_data, m_lo);
    end
  end

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 1;
    while (!(to_hi || to_lo) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eh,
                        input logic [31:0] el, input logic ewh, input logic ewl);
    int n;
    launch(o, a, b);
    wait_strobe(n);
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " to_hi"}, 32'(to_hi), 32'(ewh));
    check({name, " to_lo"}, 32'(to_lo), 32'(ewl));
    if (ewh) check({name, " hi"}, to_hi_data, eh);
    if (ewl) check({name, " lo"}, to_lo_data, el);
    @(posedge clk); #1;
    check({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (to_hi || to_lo) seen++;
      @(posedge clk); #1;
    end
    check({name, " strobes"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",  32'(busy),  32'd0);
    check("reset to_hi", 32'(to_hi), 32'd0);
    check("reset to_lo", 32'(to_lo), 32'd0);
    check("reset hi",    to_hi_data, 32'd0);
    check("reset lo",    to_lo_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mult",     OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 1);
    run_op("multu",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFE, 32'h0000_0001, 1, 1);
    run_op("div",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1);
    run_op("divu",     OP_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14,        1, 1);
    run_op("divu0",    OP_DIVU,  32'h0000_1234, 32'h0000_0000, 1,  32'h0000_1234, 32'hFFFF_FFFF, 1, 1);
    run_op("div ovf",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1, 1);
    run_op("div neg",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD, 1, 1);
    run_op("mtlo",     OP_MTLO,  32'hCAFE_BABE, 32'd0,         1,  32'd0,         32'hCAFE_BABE, 0, 1);
    run_op("mthi",     OP_MTHI,  32'h1357_9BDF, 32'd0,         1,  32'h1357_9BDF, 32'd0,         1, 0);

    // Second start at cycle 5 of a division must be ignored.
    launch(OP_DIV, 32'd1000, 32'd3);
    n = 1;
    while (!(to_hi || to_lo) && n < 60) begin
      if (n == 5) begin op = OP_MULT; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("busy start latency", 32'(n), 32'd33);
    check("busy start lo", to_lo_data, 32'd333);
    check("busy start hi", to_hi_data, 32'd1);
    @(posedge clk); #1;

    // Flush at cycle 10 of a division.
    launch(OP_DIV, 32'd12345, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    watch_quiet("flush", 40);

    // Reset at cycle 20 of a division.
    launch(OP_DIVU, 32'd99999, 32'd13);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst hi", to_hi_data, 32'd0);
    watch_quiet("rst", 40);

    run_op("mult after", OP_MULT, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 1);

    // Flush during the strobe cycle kills the strobes immediately.
    launch(OP_MULT, 32'd3, 32'd4);
    flush = 1'b1;
    #1;
    check("done flush to_hi", 32'(to_hi), 32'd0);
    check("done flush to_lo", 32'(to_lo), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("done flush busy", 32'(busy), 32'd0);

    // Start together with flush in IDLE is dropped.
    op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle flush busy", 32'(busy), 32'd0);

    // Undefined op code is ignored.
    launch(3'd6, 32'd1, 32'd2);
    check("undef busy", 32'(busy), 32'd0);
    launch(3'd7, 32'd1, 32'd2);
    check("undef7 busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Multiply/divide unit that is the write-side producer for the HI/LO register pair.
- Accepts one operation per start pulse from the EX stage: MULT, MULTU, DIV, DIVU, MTHI or MTLO.
- Computes the result, either single-cycle or iteratively, then drives a one-cycle HI/LO write strobe with data.
- Drives busy to stall the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, operand width; HI/LO width equals DATA_W. Only 32 is verified.
- DIV_ITERS, DATA_W, number of restoring-division iterations; must equal DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- start  in  1  operation request; accepted only when busy = 0.
- op  in  3  operation code, sampled with start: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- rs_data  in  DATA_W  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_data  in  DATA_W  operand B (divisor / multiplier).
- flush  in  1  cancel the in-flight operation (exception / branch squash).
- busy  out  1  high while an operation is in flight; the pipeline stalls on it.
- to_hi  out  1  one-cycle HI write strobe.
- to_lo  out  1  one-cycle LO write strobe.
- to_hi_data  out  DATA_W  HI write data, valid when to_hi = 1.
- to_lo_data  out  DATA_W  LO write data, valid when to_lo = 1.

Behaviour:
- Reset (rst = 0 at a rising edge):
  - state = IDLE; busy, to_hi, to_lo = 0; data outputs = 0; iteration counter = 0.
  - Reset wins over every other input, including mid-division.
- States:
  - IDLE: start accepted here only.
  - DIV: iterating.
  - DONE: write strobe cycle.
- Decoding: busy = (state != IDLE); outputs are registered, decoded from state.
- IDLE, start = 1, flush = 0:
  - MULT/MULTU: 64-bit product registered (signed / unsigned); -> DONE.
  - DIV/DIVU with rt_data = 0: result HI = rs_data, LO = all-ones; -> DONE.
  - DIV/DIVU with rt_data != 0: latch magnitudes (|rs|, |rt| for DIV; raw for DIVU) and sign flags; counter = 0; -> DIV.
  - MTHI / MTLO: latch rs_data; -> DONE with only to_hi / only to_lo set.
  - Undefined op codes are ignored; state stays IDLE.
- DIV state:
  - One restoring shift-subtract step per cycle; counter increments.
  - When counter = DIV_ITERS-1 the step completes and the state goes to DONE.
  - Signed fixup is applied when entering DONE: quotient negated if sign(rs) != sign(rt); remainder takes the sign of rs.
- DONE (exactly one cycle):
  - MUL/DIV: to_hi = to_lo = 1; to_hi_data = product[63:32] or remainder; to_lo_data = product[31:0] or quotient.
  - MTHI / MTLO: only the matching strobe is set.
  - Next state is IDLE.
- Latency from the start edge to the strobe cycle:
  - MULT/MULTU/MTHI/MTLO and divide-by-zero: 1 cycle.
  - DIV/DIVU: DIV_ITERS + 1 = 33 cycles.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap.
- Start while busy: ignored; no queueing, no state change.
- Flush:
  - In DIV or DONE, flush = 1 forces IDLE next cycle and suppresses the strobes; if in DONE, to_hi/to_lo are forced to 0 that same cycle.
  - In IDLE, start = 1 with flush = 1: flush wins and the start is dropped.
- Strobes are never asserted outside DONE. Data outputs hold their last value when strobes are low.

Decomposition:
- Shared definitions header holds:
  - op encodings: MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
  - state encodings IDLE/DIV/DONE;
  - DATA_W default.
- One natural sub-module: div_step. Purely combinational, one restoring iteration: (partial remainder, quotient, divisor) -> next pair.
- Multiplier stays inline using the synthesis operator.

Test Plan:
- MULT rs = 0xFFFFFFFE (-2), rt = 0x00000003: one cycle later, to_hi = to_lo = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; busy high for exactly 1 cycle.
- MULTU rs = rt = 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001 at cycle 1.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2: strobe exactly 33 cycles after start, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7: LO = 14, HI = 2.
- DIVU rs = 0x1234, rt = 0: strobe at cycle 1, HI = 0x1234, LO = 0xFFFFFFFF; DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MTLO rs = 0xCAFEBABE: cycle 1 gives to_lo = 1 with data 0xCAFEBABE and to_hi = 0. A second start during a DIV at cycle 5 is ignored, and the DIV result is unchanged.
- Start DIV, then flush at cycle 10 and separately rst = 0 at cycle 20 of another DIV: no strobe ever; busy = 0 the next cycle; a new MULT issued afterwards completes normally.
